// File: rtl/sc_to_wc_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sc_to_wc_iter
//  Purpose  : Screen-to-world coordinate converter; one shared restoring
//             divider produces floor(x*2^F/res_y) then floor(y'*2^F/res_y).
//  Revision : 1.0  initial release
// ============================================================================
module sc_to_wc_iter #(
    parameter int W  = 12,
    parameter int F  = 10,
    parameter int IW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] x,
    input  logic [IW-1:0] y,
    input  logic [IW-1:0] res_y,
    input  logic          flip_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  x_wc,
    output logic [W-1:0]  y_wc,
    output logic          sat,
    output logic          div_err
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DIV_X = 2'd1;
    localparam logic [1:0] c_ST_DIV_Y = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [CW-1:0] c_LAST    = CW'(W);
    localparam logic [CW-1:0] c_FIRST   = CW'(1);
    localparam logic [W-1:0]  c_SAT_VAL = '1;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_x;
    logic [IW-1:0]   r_yp;
    logic [IW-1:0]   r_res;
    logic [IW:0]     r_rem;
    logic [W-1:0]    r_dq;
    logic            r_ovf;
    logic [W-1:0]    r_xq;
    logic            r_sat_x;

    logic [IW-1:0]   w_yp;
    logic [IW-1:0]   w_op;
    logic [IW+F-1:0] w_dvd;
    logic [IW:0]     w_rem_init;
    logic            w_ovf_init;
    logic [IW:0]     w_trial;
    logic            w_ge;
    logic [IW:0]     w_rem_nxt;
    logic [W-1:0]    w_q;
    logic            w_err;
    logic [W-1:0]    w_q_final;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (in_valid)        w_next_state = c_ST_DIV_X;
            c_ST_DIV_X: if (r_cnt == c_LAST) w_next_state = c_ST_DIV_Y;
            c_ST_DIV_Y: if (r_cnt == c_LAST) w_next_state = c_ST_DONE;
            c_ST_DONE:  if (out_ready)       w_next_state = c_ST_IDLE;
            default:                         w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_ST_IDLE);
        out_valid = (r_state == c_ST_DONE);
    end

    // ------------------------------------------------------- combinational
    always_comb begin
        w_yp = y;
        if (flip_y) begin
            w_yp = (y < res_y) ? (res_y - y - IW'(1)) : '0;
        end
    end

    // Dividend bits above the W quotient positions seed the remainder; if that
    // seed already reaches res_y the quotient cannot fit in W bits.
    assign w_op       = (r_cnt == '0) ? r_x : r_yp;
    assign w_dvd      = {w_op, {F{1'b0}}};
    assign w_rem_init = (IW + 1)'(w_dvd >> W);
    assign w_ovf_init = (w_rem_init >= {1'b0, r_res});

    assign w_trial    = {r_rem[IW-1:0], r_dq[W-1]};
    assign w_ge       = r_rem[IW] | (w_trial >= {1'b0, r_res});
    assign w_rem_nxt  = w_ge ? (w_trial - {1'b0, r_res}) : w_trial;
    assign w_q        = {r_dq[W-2:0], w_ge};
    assign w_err      = (r_res == '0);
    assign w_q_final  = (r_ovf | w_err) ? c_SAT_VAL : w_q;

    // ----------------------------------------------------------- datapath
    // r_dq holds unconsumed dividend bits at the top and quotient bits at the
    // bottom; one bit moves across per iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_yp    <= '0;
            r_res   <= '0;
            r_rem   <= '0;
            r_dq    <= '0;
            r_ovf   <= 1'b0;
            r_xq    <= '0;
            r_sat_x <= 1'b0;
            x_wc    <= '0;
            y_wc    <= '0;
            sat     <= 1'b0;
            div_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_x   <= x;
                        r_yp  <= w_yp;
                        r_res <= res_y;
                        r_cnt <= '0;
                    end
                end
                c_ST_DIV_X: begin
                    if (r_cnt == '0) begin
                        r_rem <= w_rem_init;
                        r_dq  <= w_dvd[W-1:0];
                        r_ovf <= w_ovf_init;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dq  <= w_q;
                    end
                    if (r_cnt == c_LAST) begin
                        r_xq    <= w_q_final;
                        r_sat_x <= r_ovf & ~w_err;
                        r_rem   <= w_rem_init;
                        r_dq    <= w_dvd[W-1:0];
                        r_ovf   <= w_ovf_init;
                        r_cnt   <= c_FIRST;
                    end else begin
                        r_cnt <= r_cnt + c_FIRST;
                    end
                end
                c_ST_DIV_Y: begin
                    r_rem <= w_rem_nxt;
                    r_dq  <= w_q;
                    r_cnt <= r_cnt + c_FIRST;
                    if (r_cnt == c_LAST) begin
                        x_wc    <= r_xq;
                        y_wc    <= w_q_final;
                        sat     <= r_sat_x | (r_ovf & ~w_err);
                        div_err <= w_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_to_wc_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sc_to_wc_iter
//  Purpose  : Scoreboard bench for sc_to_wc_iter (directed + back-to-back).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sc_to_wc_iter;

    localparam int W  = 12;
    localparam int F  = 10;
    localparam int IW = 11;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [IW-1:0] x         = '0;
    logic [IW-1:0] y         = '0;
    logic [IW-1:0] res_y     = '0;
    logic          flip_y    = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  x_wc;
    logic [W-1:0]  y_wc;
    logic          sat;
    logic          div_err;

    typedef struct {
        int xw;
        int yw;
        int s;
        int e;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   acc_prev = 0;
    bit   pend     = 1'b0;
    bit   prev_ov  = 1'b0;
    bit   b2b      = 1'b0;
    bit   have_prev = 1'b0;

    sc_to_wc_iter #(.W(W), .F(F), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .res_y     (res_y),
        .flip_y    (flip_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_wc      (x_wc),
        .y_wc      (y_wc),
        .sat       (sat),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int xx, input int yy, input int rr, input bit fl);
        exp_t e;
        int   yp;
        int   qx;
        int   qy;
        e.s = 0;
        e.e = 0;
        if (rr == 0) begin
            e.xw = 4095;
            e.yw = 4095;
            e.e  = 1;
            return e;
        end
        yp = !fl ? yy : ((yy < rr) ? rr - 1 - yy : 0);
        qx = (xx * 1024) / rr;
        qy = (yp * 1024) / rr;
        if (qx > 4095) begin qx = 4095; e.s = 1; end
        if (qy > 4095) begin qy = 4095; e.s = 1; end
        e.xw = qx;
        e.yw = qy;
        return e;
    endfunction

    // Called at posedge+#1; returns at accept edge +#1.
    task automatic send(input int xx, input int yy, input int rr, input bit fl,
                        input int ex, input int ey, input int es, input int ee);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            x        = IW'(xx);
            y        = IW'(yy);
            res_y    = IW'(rr);
            flip_y   = fl;
            in_valid = 1'b1;
            e.xw = ex; e.yw = ey; e.s = es; e.e = ee;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x_wc",      int'(x_wc),      0);
        chk("rst_y_wc",      int'(y_wc),      0);
        chk("rst_sat",       int'(sat),       0);
        chk("rst_div_err",   int'(div_err),   0);
    endtask

    // Monitor: latency, accept interval and scoreboard comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend    = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov && pend) begin
                chk("latency", cyc - acc_cyc, 25);
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("x_wc",    int'(x_wc),    e.xw);
                    chk("y_wc",    int'(y_wc),    e.yw);
                    chk("sat",     int'(sat),     e.s);
                    chk("div_err", int'(div_err), e.e);
                end
            end
            if (in_valid && in_ready) begin
                if (b2b && have_prev) chk("interval", (cyc + 1) - acc_prev, 27);
                have_prev = b2b;
                acc_cyc   = cyc + 1;
                acc_prev  = cyc + 1;
                pend      = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        @(posedge clk); #1;
        chk_reset_state();
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        send(400,  200, 800, 1'b0, 512,  256,  0, 0);
        send(1279, 799, 800, 1'b0, 1637, 1022, 0, 0);
        send(1279, 799, 800, 1'b1, 1637, 0,    0, 0);
        send(1279, 0,   800, 1'b1, 1637, 1022, 0, 0);
        send(1279, 50,  100, 1'b0, 4095, 512,  1, 0);
        send(37,   5,   0,   1'b0, 4095, 4095, 0, 1);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(400, 200, 800, 1'b0, 512, 256, 0, 0);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready",  int'(in_ready),  0);
            chk("bp_x_wc",      int'(x_wc),      512);
            chk("bp_y_wc",      int'(y_wc),      256);
            in_valid = ((i % 2) == 0);
            x        = IW'(i * 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", int'(in_ready), 1);
        chk("bp_hold_x_wc",      int'(x_wc),     512);

        // Reset in the middle of DIV_Y discards the request.
        send(100, 300, 800, 1'b0, 128, 384, 0, 0);
        repeat (18) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(640, 400, 800, 1'b0, 819, 512, 0, 0);
        drain();

        // Back-to-back random traffic against the floor model.
        b2b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int   rx;
            int   ry;
            bit   rf;
            exp_t e;
            rx = int'($urandom_range(1279));
            ry = int'($urandom_range(799));
            rf = 1'($urandom_range(1));
            e  = model(rx, ry, 800, rf);
            send(rx, ry, 800, rf, e.xw, e.yw, e.s, e.e);
        end
        drain();
        b2b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
